// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: each accepted word is sent as a start bit,
// WIDTH data bits and a stop bit, with back-to-back framing when fed in STOP.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             s_out,
    output logic             s_frame,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_s_out;
    logic             w_s_out_nxt;
    logic             r_s_frame;
    logic             w_s_frame_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_accept;

    assign d_ready  = (r_state == S_IDLE) || (r_state == S_STOP);
    assign busy     = (r_state != S_IDLE);
    assign w_accept = d_valid && d_ready;
    assign s_out    = r_s_out;
    assign s_frame  = r_s_frame;
    assign done     = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_cnt_nxt     = r_cnt;
        w_s_out_nxt   = 1'b1;
        w_s_frame_nxt = 1'b0;
        w_done_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_shreg_nxt = d_in;
                end
            end
            S_START: begin
                w_state_nxt = S_DATA;
                w_cnt_nxt   = '0;
            end
            S_DATA: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_shreg_nxt = d_in;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        unique case (w_state_nxt)
            S_START: w_s_out_nxt = 1'b0;
            S_DATA: begin
                w_s_frame_nxt = 1'b1;
                if (MSB_FIRST) begin
                    w_s_out_nxt = r_shreg[WIDTH-1];
                    w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                end else begin
                    w_s_out_nxt = r_shreg[0];
                    w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
                end
            end
            S_STOP:  w_done_nxt = 1'b1;
            default: w_s_out_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_s_out   <= 1'b1;
            r_s_frame <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_shreg   <= w_shreg_nxt;
            r_cnt     <= w_cnt_nxt;
            r_s_out   <= w_s_out_nxt;
            r_s_frame <= w_s_frame_nxt;
            r_done    <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a symbol-queue model of the serial line checked every cycle,
// directed frame traces with literal expectations, and a WIDTH=8 deserializing regression.
module tb_piso_tx;

    localparam int SYM_IDLE  = 0;
    localparam int SYM_START = 1;
    localparam int SYM_D0    = 2;
    localparam int SYM_D1    = 3;
    localparam int SYM_STOP  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv  [3];
    logic [31:0] din [3];
    logic        rdy [3];
    logic        so  [3];
    logic        sf  [3];
    logic        bz  [3];
    logic        dn  [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb4 (
        .clk(clk), .rst_n(rst_n), .d_in(din[0][3:0]), .d_valid(dv[0]), .d_ready(rdy[0]),
        .s_out(so[0]), .s_frame(sf[0]), .busy(bz[0]), .done(dn[0]));
    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb4 (
        .clk(clk), .rst_n(rst_n), .d_in(din[1][3:0]), .d_valid(dv[1]), .d_ready(rdy[1]),
        .s_out(so[1]), .s_frame(sf[1]), .busy(bz[1]), .done(dn[1]));
    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
        .clk(clk), .rst_n(rst_n), .d_in(din[2][7:0]), .d_valid(dv[2]), .d_ready(rdy[2]),
        .s_out(so[2]), .s_frame(sf[2]), .busy(bz[2]), .done(dn[2]));

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, idx, $time, act, exp);
        end
    endtask

    function automatic int width_of(input int i);
        return (i == 2) ? 8 : 4;
    endfunction

    // Model: a frame is a list of line symbols queued at accept, one popped per cycle.
    int         q   [3][$];
    int         cur [3] = '{SYM_IDLE, SYM_IDLE, SYM_IDLE};
    logic [7:0] exp8[$];
    int         acc_cnt2 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                q[i].delete();
                cur[i] = SYM_IDLE;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (dv[i] === 1'b1 && (cur[i] == SYM_IDLE || cur[i] == SYM_STOP)) begin
                    int w;
                    w = width_of(i);
                    q[i].push_back(SYM_START);
                    for (int b = 0; b < w; b++) begin
                        int pos;
                        pos = (i == 1) ? (w - 1 - b) : b;
                        q[i].push_back(din[i][pos] ? SYM_D1 : SYM_D0);
                    end
                    q[i].push_back(SYM_STOP);
                    if (i == 2) begin
                        exp8.push_back(din[2][7:0]);
                        acc_cnt2++;
                    end
                end
                cur[i] = (q[i].size() == 0) ? SYM_IDLE : q[i].pop_front();
            end
        end
    end

    int         done_cnt2 = 0;
    int         bit_idx   = 0;
    logic [7:0] sreg;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int s;
            s = cur[i];
            check("s_out",   i, 32'(so[i]),  32'(s != SYM_START && s != SYM_D0));
            check("s_frame", i, 32'(sf[i]),  32'(s == SYM_D0 || s == SYM_D1));
            check("done",    i, 32'(dn[i]),  32'(s == SYM_STOP));
            check("busy",    i, 32'(bz[i]),  32'(s != SYM_IDLE));
            check("d_ready", i, 32'(rdy[i]), 32'(s == SYM_IDLE || s == SYM_STOP));
        end
        if (!rst_n) begin
            bit_idx = 0;
        end else begin
            if (sf[2] === 1'b1 && bit_idx < 8) begin
                sreg[bit_idx] = so[2];
                bit_idx++;
            end
            if (dn[2] === 1'b1) begin
                check("deser_bits", 2, 32'(bit_idx), 32'd8);
                if (exp8.size() == 0) begin
                    check("deser_extra", 2, 32'd1, 32'd0);
                end else begin
                    check("deser_word", 2, 32'(sreg), 32'(exp8.pop_front()));
                end
                done_cnt2++;
                bit_idx = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic trace6(input int i, output logic [5:0] so_t, output logic [5:0] sf_t,
                          output logic [5:0] dn_t);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            so_t[k] = so[i];
            sf_t[k] = sf[i];
            dn_t[k] = dn[i];
        end
    endtask

    initial begin
        logic [5:0]  t_so, t_sf, t_dn;
        logic [11:0] t12_so, t12_bz;
        for (int i = 0; i < 3; i++) begin
            dv[i]  = 1'b0;
            din[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_s_out",   i, 32'(so[i]),  32'd1);
            check("rst_s_frame", i, 32'(sf[i]),  32'd0);
            check("rst_done",    i, 32'(dn[i]),  32'd0);
            check("rst_busy",    i, 32'(bz[i]),  32'd0);
            check("rst_d_ready", i, 32'(rdy[i]), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single word LSB first: 1011 -> 0,1,1,0,1,1
        tick();
        dv[0] = 1'b1; din[0] = 32'hB;
        tick();
        dv[0] = 1'b0;
        trace6(0, t_so, t_sf, t_dn);
        check("lsb_trace_s_out",   0, 32'(t_so), 32'b110110);
        check("lsb_trace_s_frame", 0, 32'(t_sf), 32'b011110);
        check("lsb_trace_done",    0, 32'(t_dn), 32'b100000);
        @(negedge clk);
        check("lsb_idle_s_out", 0, 32'(so[0]), 32'd1);
        check("lsb_idle_busy",  0, 32'(bz[0]), 32'd0);

        // Single word MSB first: 1011 -> 0,1,0,1,1,1
        tick();
        dv[1] = 1'b1; din[1] = 32'hB;
        tick();
        dv[1] = 1'b0;
        trace6(1, t_so, t_sf, t_dn);
        check("msb_trace_s_out", 1, 32'(t_so), 32'b111010);
        check("msb_trace_done",  1, 32'(t_dn), 32'b100000);

        // Back-to-back A then 5 with d_valid held high
        repeat (2) tick();
        dv[0] = 1'b1; din[0] = 32'hA;
        tick();
        din[0] = 32'h5;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            t12_so[k] = so[0];
            t12_bz[k] = bz[0];
            if (k == 6) dv[0] = 1'b0;
        end
        check("b2b_s_out", 0, 32'(t12_so), 32'b101010110100);
        check("b2b_busy",  0, 32'(t12_bz), 32'hFFF);
        repeat (4) tick();

        // Hold-off: d_in scrambled while the frame is in flight
        dv[1] = 1'b1; din[1] = 32'h6;
        tick();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            t_so[k] = so[1];
            if (k < 5) begin
                check("holdoff_d_ready", 1, 32'(rdy[1]), 32'd0);
                din[1] = $urandom;
                dv[1]  = 1'b1;
            end else begin
                dv[1] = 1'b0;
            end
        end
        check("holdoff_s_out", 1, 32'(t_so), 32'b101100);
        repeat (3) tick();

        // Asynchronous reset in the second DATA cycle, then accept on first edge after release
        dv[0] = 1'b1; din[0] = 32'h9;
        tick();
        dv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_s_out",   0, 32'(so[0]),  32'd1);
        check("midrst_busy",    0, 32'(bz[0]),  32'd0);
        check("midrst_d_ready", 0, 32'(rdy[0]), 32'd1);
        check("midrst_s_frame", 0, 32'(sf[0]),  32'd0);
        @(negedge clk);
        din[0] = 32'h3; dv[0] = 1'b1; rst_n = 1'b1;
        tick();
        dv[0] = 1'b0;
        trace6(0, t_so, t_sf, t_dn);
        check("postrst_s_out", 0, 32'(t_so), 32'b100110);
        repeat (3) tick();

        // WIDTH=8 regression with random gaps
        for (int w = 0; w < 1000; w++) begin
            int n;
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            dv[2] = 1'b1; din[2] = $urandom;
            n = 0;
            while (rdy[2] !== 1'b1 && n < 30) begin
                tick();
                n++;
            end
            if (n >= 30) check("regr_ready_timeout", 2, 32'(n), 32'd0);
            tick();
            dv[2] = 1'b0;
        end
        repeat (15) tick();
        check("regr_accepts", 2, 32'(acc_cnt2), 32'd1000);
        check("regr_done_count", 2, 32'(done_cnt2), 32'(acc_cnt2));
        check("regr_pending", 2, 32'(exp8.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4, parallel word width; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0; 0 = LSB shifted first, 1 = MSB shifted first.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 d_in  input  WIDTH  parallel word to transmit.
REQ-006 d_valid  input  1  d_in holds a word to send.
REQ-007 d_ready  output  1  block can accept a word this cycle.
REQ-008 s_out  output  1  serial line; idles high.
REQ-009 s_frame  output  1  high while s_out carries a data bit.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  high for exactly the STOP cycle of each frame.

Function
REQ-012 The block SHALL implement states IDLE, START, DATA, STOP.
REQ-013 A word SHALL be accepted on a posedge where d_valid && d_ready; d_in SHALL be captured into an internal WIDTH-bit shift register on that edge.
REQ-014 d_ready SHALL be high in IDLE and STOP, low in START and DATA; it SHALL be decoded from state only, with no combinational path from d_valid.
REQ-015 Transitions: IDLE->START on accept; START->DATA unconditionally; DATA->STOP after WIDTH data cycles; STOP->START on accept, else STOP->IDLE.
REQ-016 Frame, one cycle per symbol: START s_out=0; DATA s_out = current data bit, WIDTH cycles; STOP s_out=1. Each frame SHALL occupy WIDTH+2 cycles.
REQ-017 Latency: s_out SHALL show the start bit in the first cycle after the accepting edge.
REQ-018 Bit order: bit 0 first when MSB_FIRST=0; bit WIDTH-1 first when MSB_FIRST=1.
REQ-019 The bit counter SHALL be $clog2(WIDTH) bits, cleared on entering DATA, and incremented once per DATA cycle; DATA SHALL exit when the count equals WIDTH-1.
REQ-020 s_out, s_frame and done SHALL be registered outputs, glitch-free.
REQ-021 s_frame SHALL be high exactly in DATA cycles.
REQ-022 busy SHALL be high in START, DATA and STOP.
REQ-023 Changes on d_in or d_valid while d_ready=0 SHALL have no effect on the frame in flight.
REQ-024 Back-to-back: an accept in STOP SHALL start the next START bit on the following cycle, with no IDLE gap.
REQ-025 d_valid low in STOP SHALL return the block to IDLE; s_out SHALL then stay high.

Reset
REQ-026 While rst_n=0, the block SHALL force: state=IDLE, shift register=0, counter=0, s_out=1, s_frame=0, done=0, busy=0, d_ready=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, without waiting for a clock edge; the partial word SHALL be discarded.
REQ-028 After rst_n rises, the first accept SHALL be possible on the first posedge.

Verification (WIDTH=4 unless stated)
REQ-029 Single word, MSB_FIRST=0: d_in=4'b1011 with a one-cycle d_valid pulse from IDLE -> s_out=0,1,1,0,1,1; s_frame high for cycles 2-5; done high in cycle 6; then IDLE with s_out=1.
REQ-030 MSB_FIRST=1: d_in=4'b1011 -> s_out=0,1,0,1,1,1.
REQ-031 Back-to-back: d_valid held high with 4'hA then 4'h5 -> 12 contiguous cycles s_out=0,0,1,0,1,1,0,1,0,1,0,1; no idle cycle between frames.
REQ-032 Hold-off: d_in toggled randomly during START/DATA with d_valid=1 -> transmitted bits match the word captured at accept; d_ready=0 throughout.
REQ-033 Reset mid-frame: rst_n pulled low in the second DATA cycle, between clock edges -> s_out=1, busy=0, d_ready=1 immediately; the next frame after release is correct.
REQ-034 WIDTH=8 random regression: 1000 words with random d_valid gaps -> a scoreboard deserializing on s_frame matches every accepted word, and the done count equals the accept count.
